// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: accepts one ALU op per valid/ready handshake and drives registered control words.
// Optional macro ALUSEQ_ITER_SHIFT_EN: iterative shifter, one bit position per SH_RUN cycle.
module alu_op_sequencer #(
  parameter int OP_W      = 4,
  parameter int SHAMT_W   = 5,
  parameter int LUI_SHAMT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [OP_W-1:0]    op,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [2:0]         ALU_control,
  output logic [2:0]         SHIFTER_control,
  output logic [SHAMT_W-1:0] shift_n,
  output logic               M_SHIFTER,
  output logic [1:0]         M_ALUOut_control,
  output logic               UC_control,
  output logic [1:0]         UC_op,
  output logic [1:0]         ulaaux_control,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    SH_LOAD = 2'd2,
    SH_RUN  = 2'd3
  } state_t;

  typedef struct packed {
    logic [2:0]         alu;
    logic [2:0]         shc;
    logic [SHAMT_W-1:0] shn;
    logic               msh;
    logic [1:0]         mout;
    logic               ucc;
    logic [1:0]         ucop;
    logic [1:0]         ula;
  } ctrl_t;

  localparam logic [3:0] OP_NOP       = 4'd0;
  localparam logic [3:0] OP_ADD       = 4'd1;
  localparam logic [3:0] OP_SUB       = 4'd2;
  localparam logic [3:0] OP_AND       = 4'd3;
  localparam logic [3:0] OP_PASS_B    = 4'd4;
  localparam logic [3:0] OP_SHIFT_L1  = 4'd5;
  localparam logic [3:0] OP_SHIFT_L2  = 4'd6;
  localparam logic [3:0] OP_SHIFT_R   = 4'd7;
  localparam logic [3:0] OP_SHIFT_RA1 = 4'd8;
  localparam logic [3:0] OP_SHIFT_RA2 = 4'd9;
  localparam logic [3:0] OP_SLTI      = 4'd10;
  localparam logic [3:0] OP_BEQ       = 4'd11;
  localparam logic [3:0] OP_BNE       = 4'd12;
  localparam logic [3:0] OP_BLE       = 4'd13;
  localparam logic [3:0] OP_BGT       = 4'd14;
  localparam logic [3:0] OP_LUI       = 4'd15;

  localparam logic [SHAMT_W-1:0] LUI_DIST = SHAMT_W'(LUI_SHAMT);

  // Any opcode with bits above the low nibble set is treated as NO_OP.
  function automatic logic [3:0] op_code(input logic [OP_W-1:0] o);
    logic [3:0] c;
    if ((o >> 3'd4) != {OP_W{1'b0}}) begin
      c = OP_NOP;
    end else begin
      c = o[3:0];
    end
    return c;
  endfunction

  function automatic logic is_multi(input logic [3:0] c);
    logic m;
    case (c)
      OP_SHIFT_L1, OP_SHIFT_R, OP_SHIFT_RA1, OP_LUI: m = 1'b1;
      default:                                       m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic [2:0] run_code(input logic [3:0] c);
    logic [2:0] r;
    case (c)
      OP_SHIFT_L1, OP_LUI: r = 3'b010;
      OP_SHIFT_R:          r = 3'b011;
      OP_SHIFT_RA1:        r = 3'b100;
      default:             r = 3'b000;
    endcase
    return r;
  endfunction

  function automatic ctrl_t exec_word(input logic [3:0] c);
    ctrl_t w;
    w = '0;
    case (c)
      OP_ADD:       begin w.alu = 3'b001; w.mout = 2'b01; end
      OP_SUB:       begin w.alu = 3'b010; w.mout = 2'b01; end
      OP_AND:       begin w.alu = 3'b011; w.mout = 2'b01; end
      OP_PASS_B:    begin w.alu = 3'b000; w.mout = 2'b00; end
      OP_SHIFT_L2:  begin w.shc = 3'b010; w.mout = 2'b10; w.ula = 2'b01; end
      OP_SHIFT_RA2: begin w.shc = 3'b010; w.mout = 2'b10; w.ula = 2'b10; end
      OP_SLTI:      begin w.alu = 3'b111; w.mout = 2'b11; end
      OP_BEQ:       begin w.alu = 3'b111; w.mout = 2'b11; w.ucc = 1'b1; w.ucop = 2'b00; end
      OP_BNE:       begin w.alu = 3'b111; w.mout = 2'b11; w.ucc = 1'b1; w.ucop = 2'b01; end
      OP_BLE:       begin w.alu = 3'b111; w.mout = 2'b11; w.ucc = 1'b1; w.ucop = 2'b10; end
      OP_BGT:       begin w.alu = 3'b111; w.mout = 2'b11; w.ucc = 1'b1; w.ucop = 2'b11; end
      default:      begin w.alu = 3'b000; w.mout = 2'b01; end
    endcase
    return w;
  endfunction

  state_t             state_r, state_nxt_s;
  logic [3:0]         op_r, op_nxt_s;
  ctrl_t              ctrl_r, ctrl_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic               done_r, done_nxt_s;
  logic               ready_r, ready_nxt_s;
  logic               accept_s, take_new_s;
  logic [3:0]         code_in_s;
  logic [SHAMT_W-1:0] dist_in_s;
`ifdef ALUSEQ_ITER_SHIFT_EN
  logic [SHAMT_W-1:0] cnt_r, cnt_nxt_s;
`else
  logic [SHAMT_W-1:0] dist_r, dist_nxt_s;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and next control word; outputs are registered from these.
  always_comb begin
    state_nxt_s = state_r;
    op_nxt_s    = op_r;
    ctrl_nxt_s  = '0;
    busy_nxt_s  = 1'b0;
    done_nxt_s  = 1'b0;
    take_new_s  = 1'b0;
`ifdef ALUSEQ_ITER_SHIFT_EN
    cnt_nxt_s   = cnt_r;
`else
    dist_nxt_s  = dist_r;
`endif
    accept_s  = op_valid && ready_r;
    code_in_s = op_code(op);
    dist_in_s = (code_in_s == OP_LUI) ? LUI_DIST : shamt;

    case (state_r)
      IDLE:    take_new_s = 1'b1;
      EXEC:    take_new_s = 1'b1;
      SH_LOAD: take_new_s = 1'b0;
`ifdef ALUSEQ_ITER_SHIFT_EN
      SH_RUN:  take_new_s = done_r;
`else
      SH_RUN:  take_new_s = 1'b1;
`endif
      default: take_new_s = 1'b1;
    endcase

    if (take_new_s) begin
      if (accept_s) begin
        op_nxt_s   = code_in_s;
        busy_nxt_s = 1'b1;
        if (is_multi(code_in_s)) begin
          state_nxt_s     = SH_LOAD;
          ctrl_nxt_s.shc  = 3'b001;
          ctrl_nxt_s.mout = 2'b10;
          ctrl_nxt_s.msh  = (code_in_s == OP_LUI);
`ifdef ALUSEQ_ITER_SHIFT_EN
          cnt_nxt_s       = dist_in_s;
`else
          dist_nxt_s      = dist_in_s;
`endif
        end else begin
          state_nxt_s = EXEC;
          ctrl_nxt_s  = exec_word(code_in_s);
          done_nxt_s  = 1'b1;
        end
      end else begin
        state_nxt_s = IDLE;
      end
    end else begin
      // One shifter step; mux selects carry over from the load cycle.
      state_nxt_s     = SH_RUN;
      busy_nxt_s      = 1'b1;
      ctrl_nxt_s.msh  = ctrl_r.msh;
      ctrl_nxt_s.mout = 2'b10;
`ifdef ALUSEQ_ITER_SHIFT_EN
      if (cnt_r == {SHAMT_W{1'b0}}) begin
        ctrl_nxt_s.shc = 3'b000;
        done_nxt_s     = 1'b1;
      end else begin
        ctrl_nxt_s.shc = run_code(op_r);
        ctrl_nxt_s.shn = SHAMT_W'(1'b1);
        done_nxt_s     = (cnt_r == SHAMT_W'(1'b1));
        cnt_nxt_s      = cnt_r - SHAMT_W'(1'b1);
      end
`else
      ctrl_nxt_s.shc = run_code(op_r);
      ctrl_nxt_s.shn = dist_r;
      done_nxt_s     = 1'b1;
`endif
    end

    ready_nxt_s = (state_nxt_s == IDLE) || done_nxt_s;
  end

  // Latched op, step counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r    <= OP_NOP;
      ctrl_r  <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
`ifdef ALUSEQ_ITER_SHIFT_EN
      cnt_r   <= {SHAMT_W{1'b0}};
`else
      dist_r  <= {SHAMT_W{1'b0}};
`endif
    end else begin
      op_r    <= op_nxt_s;
      ctrl_r  <= ctrl_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      ready_r <= ready_nxt_s;
`ifdef ALUSEQ_ITER_SHIFT_EN
      cnt_r   <= cnt_nxt_s;
`else
      dist_r  <= dist_nxt_s;
`endif
    end
  end

  assign op_ready         = ready_r;
  assign ALU_control      = ctrl_r.alu;
  assign SHIFTER_control  = ctrl_r.shc;
  assign shift_n          = ctrl_r.shn;
  assign M_SHIFTER        = ctrl_r.msh;
  assign M_ALUOut_control = ctrl_r.mout;
  assign UC_control       = ctrl_r.ucc;
  assign UC_op            = ctrl_r.ucop;
  assign ulaaux_control   = ctrl_r.ula;
  assign busy             = busy_r;
  assign done             = done_r;

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Parametrised successor to the multicycle datapath's ALU control decoder. Accepts one ALU operation at a time through a valid/ready handshake, then drives registered control words for the ALU, shifter, ulaaux, ALUOut mux and branch-condition unit. Multi-cycle shift ops are sequenced internally with an explicit busy/done protocol. Sits between the main control FSM and the execute-stage datapath.

## Interface
- OP_W, 4: opcode width, ≥4; codes ≥16 decode as NO_OP.
- SHAMT_W, 5: shift-amount width.
- LUI_SHAMT, 16: shift distance applied for LUI.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- op_valid  in  1  operation request
- op_ready  out  1  block can accept op this cycle
- op  in  OP_W  opcode
- shamt  in  SHAMT_W  shift amount, sampled with op
- ALU_control  out  3  ALU function
- SHIFTER_control  out  3  000 nop, 001 load, 010 sll, 011 srl, 100 sra
- shift_n  out  SHAMT_W  shifter distance
- M_SHIFTER  out  1  shifter input select (1 = immediate, LUI)
- M_ALUOut_control  out  2  00 ulaaux, 01 ALU, 10 shifter, 11 ALU compare
- UC_control  out  1  branch-condition enable
- UC_op  out  2  00 eq, 01 ne, 10 le, 11 gt
- ulaaux_control  out  2  ulaaux function
- busy  out  1  op in progress
- done  out  1  one-cycle pulse, last control cycle of an op

## Operation
- Opcodes: 0 NO_OP, 1 ADD, 2 SUB, 3 AND, 4 PASS_B, 5 SHIFT_L1, 6 SHIFT_L2, 7 SHIFT_R, 8 SHIFT_RA1, 9 SHIFT_RA2, 10 SLTI, 11 BEQ, 12 BNE, 13 BLE, 14 BGT, 15 LUI.
- Handshake: accept when op_valid && op_ready; op and shamt are latched. op_ready = 1 in IDLE and in any cycle where done = 1. Back-to-back issue is allowed.
- States:
  - IDLE: all controls 0, busy 0, done 0.
  - EXEC: single-cycle ops. Controls for 1 cycle, done = 1, then IDLE, or the next accepted op.
  - SH_LOAD: SHIFTER_control 001, shift_n 0, M_ALUOut_control 10; M_SHIFTER 1 only for LUI.
  - SH_RUN: shift codes below; M_SHIFTER and M_ALUOut hold their SH_LOAD values.
- EXEC words:
  - NO_OP: ALU 000, ALUOut 01.
  - ADD: ALU 001, ALUOut 01.
  - SUB: ALU 010, ALUOut 01.
  - AND: ALU 011, ALUOut 01.
  - PASS_B: ALU 000, ALUOut 00.
  - SHIFT_L2: SHIFTER 010, ALUOut 10, ulaaux 01.
  - SHIFT_RA2: SHIFTER 010, ALUOut 10, ulaaux 10.
  - SLTI: ALU 111, ALUOut 11, UC_control 0.
  - BEQ/BNE/BLE/BGT: ALU 111, ALUOut 11, UC_control 1, UC_op 00/01/10/11.
  - Unlisted fields are 0.
- SH_RUN shift codes: SHIFT_L1 and LUI use 010; SHIFT_R uses 011; SHIFT_RA1 uses 100.
- Shift distance is shamt, or LUI_SHAMT for LUI. The distance is truncated to SHAMT_W bits.
- Baseline (no macro): SH_RUN lasts 1 cycle, shift_n = distance, done = 1.

## Timing
- Accept at edge k; first control word is visible after edge k (cycle k+1). All outputs are registered.
- Latency: single-cycle ops take 1 control cycle. Shift ops take 2 control cycles (baseline).
- busy = 1 in every non-IDLE cycle.
- reset at any time, including mid-shift: next cycle is IDLE, all outputs 0, step counter cleared, latched op discarded.
- op_valid while busy and done = 0: ignored, no latch.

## Configuration
- ALUSEQ_ITER_SHIFT_EN defined: SH_RUN repeats for distance cycles with shift_n = 1 each cycle. A down-counter is loaded at SH_LOAD; done is asserted in the final step.
  - Distance 0: a single SH_RUN cycle with SHIFTER_control 000 and done = 1.
  - LUI takes 1 + LUI_SHAMT control cycles.
- Not defined: baseline single SH_RUN cycle, and no step counter is synthesised.

## Test plan
- reset held 2 cycles, then released: all outputs 0, op_ready 1, busy 0.
- Issue ADD, then BNE back-to-back (op_valid held):
  - ADD cycle: ALU 001, ALUOut 01, done 1.
  - Next cycle: ALU 111, UC_control 1, UC_op 01, done 1.
- SHIFT_R, shamt 7, baseline:
  - Cycle 1: SHIFTER 001.
  - Cycle 2: SHIFTER 011, shift_n 7, done 1.
  - op_ready 0 in cycle 1.
- LUI with ALUSEQ_ITER_SHIFT_EN, LUI_SHAMT 16:
  - M_SHIFTER 1 throughout.
  - 1 load cycle, then 16 cycles of SHIFTER 010 with shift_n 1.
  - done only on cycle 17.
- SHIFT_RA1 with ITER, shamt 0: load, then one cycle SHIFTER 000, done 1.
- reset asserted in SH_RUN (ITER, shamt 20, step 5): next cycle all outputs 0, IDLE; a fresh SUB issues normally.
